imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 118 +++++++++++
 tb/tb_imm_extend_pipe.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extender (zero / sign / sign-shift / upper placement) behind a 1-cycle
// valid/ready stage with a 2-entry output buffer. Optional Ovf output under IMM_EXT_OVF_EN.
module imm_extend_pipe #(
    parameter int IMM_W = 2,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [IMM_W-1:0] Imm,
    input  logic [1:0]       Mode,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [OUT_W-1:0] Output
`ifdef IMM_EXT_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

    logic [1:0]       state, state_nxt;
    logic [OUT_W-1:0] main_q, skid_q;
    logic             in_ready_q;
    logic             xfer_in, xfer_out;
    logic             load_main_new, load_main_skid, load_skid;

    logic [OUT_W-1:0] ext_zero, ext_sign, ext_shl, ext_upper, result;

    always_comb begin
        ext_zero               = '0;
        ext_zero[IMM_W-1:0]    = Imm;
        ext_sign               = {OUT_W{Imm[IMM_W-1]}};
        ext_sign[IMM_W-1:0]    = Imm;
        ext_shl                = ext_sign << SHIFT;
        ext_upper              = '0;
        ext_upper[OUT_W-1 -: IMM_W] = Imm;
        case (Mode)
            2'b00:   result = ext_zero;
            2'b01:   result = ext_sign;
            2'b10:   result = ext_shl;
            default: result = ext_upper;
        endcase
    end

`ifdef IMM_EXT_OVF_EN
    logic [SHIFT:0] ovf_top;
    logic           ovf_res, main_ovf, skid_ovf;

    // Shifting out bits that differ from the new sign bit changes the value.
    always_comb begin
        ovf_top = ext_sign[OUT_W-1 -: SHIFT+1];
        ovf_res = (Mode == 2'b10) && !((&ovf_top) || !(|ovf_top));
    end
`endif

    assign Out_valid = (state != EMPTY);
    assign In_ready  = in_ready_q;
    assign Output    = main_q;
    assign xfer_in   = In_valid && in_ready_q;
    assign xfer_out  = Out_valid && Out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (xfer_in) state_nxt = ONE;
            ONE: begin
                if (xfer_in && !xfer_out)      state_nxt = FULL;
                else if (!xfer_in && xfer_out) state_nxt = EMPTY;
            end
            FULL:  if (xfer_out) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        load_main_new  = (state == EMPTY && xfer_in) || (state == ONE && xfer_in && xfer_out);
        load_main_skid = (state == FULL) && xfer_out;
        load_skid      = (state == ONE) && xfer_in && !xfer_out;
    end

    // In_ready is registered from the next state so Out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (load_main_new)       main_q <= result;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= result;
        end
    end

`ifdef IMM_EXT_OVF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_ovf <= 1'b0;
            skid_ovf <= 1'b0;
        end else begin
            if (load_main_new)       main_ovf <= ovf_res;
            else if (load_main_skid) main_ovf <= skid_ovf;
            if (load_skid)           skid_ovf <= ovf_res;
        end
    end

    assign Ovf = main_ovf;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized + directed bench for imm_extend_pipe against an arithmetic reference
// model and an occupancy/order scoreboard.
module tb_imm_extend_pipe;

    localparam int IMM_W = 2;
    localparam int OUT_W = 8;
    localparam int SHIFT = 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             In_valid = 1'b0;
    logic             In_ready;
    logic [IMM_W-1:0] Imm = '0;
    logic [1:0]       Mode = '0;
    logic             Out_valid;
    logic             Out_ready = 1'b0;
    logic [OUT_W-1:0] Output;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IMM_W(IMM_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset_n(reset_n), .In_valid(In_valid), .In_ready(In_ready),
        .Imm(Imm), .Mode(Mode), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Output(Output)
    );

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [OUT_W-1:0] q[$];
    bit               armed = 0;
    bit               stalled = 0;
    logic [OUT_W-1:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Extension computed with signed integer arithmetic, then reduced mod 2^OUT_W.
    function automatic logic [OUT_W-1:0] ref_ext(input int imm, input int mode);
        longint s, v;
        s = imm;
        if (imm >= (1 << (IMM_W - 1))) s = longint'(imm) - (longint'(1) << IMM_W);
        case (mode)
            0:       v = imm;
            1:       v = s;
            2:       v = s * (longint'(1) << SHIFT);
            default: v = longint'(imm) * (longint'(1) << (OUT_W - IMM_W));
        endcase
        return v[OUT_W-1:0];
    endfunction

    task automatic step(input logic v, input logic [1:0] m, input logic [IMM_W-1:0] i,
                        input logic r, input bit kat_en = 0, input logic [OUT_W-1:0] kat = '0);
        bit xin, xout;
        In_valid = v; Mode = m; Imm = i; Out_ready = r;
        @(negedge clk);
        chk("out_valid", 32'(Out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(In_ready), 32'(armed && q.size() < 2));
        if (q.size() > 0) chk("output", 32'(Output), 32'(q[0]));
        if (stalled) chk("hold", 32'(Output), 32'(held));
        if (kat_en) chk("kat", 32'(Output), 32'(kat));
        xin  = v && armed && (q.size() < 2);
        xout = (q.size() > 0) && r;
        stalled = (q.size() > 0) && !r;
        held = Output;
        @(posedge clk);
        if (xout) void'(q.pop_front());
        if (xin) q.push_back(ref_ext(int'(i), int'(m)));
        #1;
    endtask

    task automatic release_reset();
        In_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rdy_pre_edge", 32'(In_ready), 32'd0);
        @(posedge clk);
        #1;
        armed = 1;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 32'(Out_valid), 32'd0);
        chk("rst_in_ready", 32'(In_ready), 32'd0);
        chk("rst_output", 32'(Output), 32'd0);
        release_reset();

        // Imm=10 in all four modes back to back, no bubbles
        step(1, 2'd0, 2'b10, 1);
        step(1, 2'd1, 2'b10, 1, 1, 8'h02);
        step(1, 2'd2, 2'b10, 1, 1, 8'hFE);
        step(1, 2'd3, 2'b10, 1, 1, 8'hFC);
        step(0, 2'd0, 2'b00, 1, 1, 8'h80);

        step(1, 2'd2, 2'b11, 1);
        step(1, 2'd3, 2'b01, 1, 1, 8'hFE);
        step(0, 2'd0, 2'b00, 1, 1, 8'h40);
        step(0, 2'd0, 2'b00, 1);

        // Backpressure: two accepted, third waits for In_ready
        step(1, 2'd0, 2'b01, 0);
        step(1, 2'd0, 2'b10, 0);
        step(1, 2'd0, 2'b11, 0);
        step(1, 2'd0, 2'b11, 0);
        step(1, 2'd0, 2'b11, 1, 1, 8'h01);
        step(1, 2'd0, 2'b11, 1, 1, 8'h02);
        step(0, 2'd0, 2'b00, 1, 1, 8'h03);
        step(0, 2'd0, 2'b00, 1);

        // Reset while FULL
        step(1, 2'd0, 2'b01, 0);
        step(1, 2'd0, 2'b10, 0);
        step(0, 2'd0, 2'b00, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(Out_valid), 32'd0);
        chk("midrst_in_ready", 32'(In_ready), 32'd0);
        chk("midrst_output", 32'(Output), 32'd0);
        q.delete();
        armed = 0;
        stalled = 0;
        release_reset();
        step(1, 2'd1, 2'b11, 1);
        step(0, 2'd0, 2'b00, 1, 1, 8'hFF);

        repeat (1000)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), IMM_W'($urandom),
                 1'($urandom_range(0, 3) != 0));
        repeat (3) step(0, 2'd0, 2'b00, 1);
        chk("drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
